// File: rtl/note_sequencer.sv
// Falling-note rhythm game core: spawns notes from an LFSR, moves them per frame,
// scores button hits inside the hit window and ends the game after too many misses.
module note_sequencer #(
    parameter int LANES        = 4,
    parameter int SPEED        = 4,
    parameter int SPAWN_PERIOD = 30,
    parameter int HIT_Y_MIN    = 400,
    parameter int HIT_Y_MAX    = 440,
    parameter int SCREEN_H     = 480,
    parameter int POINTS       = 10,
    parameter int MAX_MISSES   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic [LANES-1:0]      buttons,
    output logic [LANES-1:0]      note_active,
    output logic [LANES*10-1:0]   note_y,
    output logic [19:0]           score,
    output logic [7:0]            combo,
    output logic [3:0]            misses,
    output logic [1:0]            state,
    output logic [LANES-1:0]      hit_pulse
);
    // state | meaning
    // IDLE  | waiting for start after reset
    // PLAY  | notes spawn, fall and are scored
    // OVER  | miss limit reached, everything frozen until start
    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;

    localparam int         CW        = $clog2(SPAWN_PERIOD + 1);
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam int         SCORE_MAX = 999999;

    state_t          st;
    logic [CW-1:0]   spawn_cnt;
    logic [7:0]      lfsr;
    logic [LANES-1:0] btn_q;

    logic [LANES-1:0]    press, act_nxt, hit_nxt;
    logic [LANES*10-1:0] y_nxt;
    logic                spawn_now, clear_combo;
    int                  hits, miss_cnt, spawn_lane;
    logic [10:0]         y_move;
    logic [31:0]         score_sum, combo_sum, miss_sum;

    always_comb begin
        press       = buttons & ~btn_q;
        spawn_now   = frame_tick && (spawn_cnt == CW'(SPAWN_PERIOD - 1));
        spawn_lane  = int'(lfsr[1:0]) % LANES;
        act_nxt     = note_active;
        y_nxt       = note_y;
        hit_nxt     = '0;
        hits        = 0;
        miss_cnt    = 0;
        clear_combo = 1'b0;
        y_move      = '0;
        for (int i = 0; i < LANES; i++) begin
            y_move = {1'b0, note_y[10*i +: 10]} + 11'(SPEED);
            // hit test uses the Y before this frame's move
            if (press[i] && note_active[i] &&
                note_y[10*i +: 10] >= 10'(HIT_Y_MIN) &&
                note_y[10*i +: 10] <= 10'(HIT_Y_MAX)) begin
                act_nxt[i] = 1'b0;
                hit_nxt[i] = 1'b1;
                hits       = hits + 1;
            end else begin
                if (press[i])
                    clear_combo = 1'b1;
                if (frame_tick && note_active[i]) begin
                    y_nxt[10*i +: 10] = y_move[9:0];
                    if (y_move >= 11'(SCREEN_H)) begin
                        act_nxt[i]  = 1'b0;
                        miss_cnt    = miss_cnt + 1;
                        clear_combo = 1'b1;
                    end
                end else if (spawn_now && !note_active[i] && spawn_lane == i) begin
                    act_nxt[i]        = 1'b1;
                    y_nxt[10*i +: 10] = '0;
                end
            end
        end
        score_sum = 32'(score) + 32'(hits) * 32'(POINTS) + 32'(hits) * 32'(combo);
        combo_sum = 32'(combo) + 32'(hits);
        miss_sum  = 32'(misses) + 32'(miss_cnt);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            score       <= '0;
            combo       <= '0;
            misses      <= '0;
            note_active <= '0;
            note_y      <= '0;
            hit_pulse   <= '0;
            spawn_cnt   <= '0;
            lfsr        <= LFSR_SEED;
            btn_q       <= '0;
        end else begin
            btn_q     <= buttons;
            hit_pulse <= '0;
            case (st)
                IDLE, OVER: begin
                    if (start) begin
                        st          <= PLAY;
                        score       <= '0;
                        combo       <= '0;
                        misses      <= '0;
                        spawn_cnt   <= '0;
                        note_active <= '0;
                        note_y      <= '0;
                    end
                end
                PLAY: begin
                    if (32'(misses) >= 32'(MAX_MISSES)) begin
                        st <= OVER;
                    end else begin
                        note_active <= act_nxt;
                        note_y      <= y_nxt;
                        hit_pulse   <= hit_nxt;
                        score       <= (score_sum > 32'(SCORE_MAX)) ? 20'(SCORE_MAX) : score_sum[19:0];
                        combo       <= clear_combo ? 8'd0 :
                                       (combo_sum > 32'd255) ? 8'hFF : combo_sum[7:0];
                        misses      <= (miss_sum > 32'd15) ? 4'hF : miss_sum[3:0];
                        if (frame_tick) begin
                            spawn_cnt <= spawn_now ? '0 : spawn_cnt + 1'b1;
                            if (spawn_now)
                                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign state = st;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: spawn, hit, miss, empty press, game over, restart,
// score saturation (second instance with large POINTS) and asynchronous reset.
module tb_note_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  buttons = 4'b0;

    logic [3:0]  note_active, note_active_b;
    logic [39:0] note_y, note_y_b;
    logic [19:0] score, score_b;
    logic [7:0]  combo, combo_b;
    logic [3:0]  misses, misses_b;
    logic [1:0]  state, state_b;
    logic [3:0]  hit_pulse, hit_pulse_b;

    int tests = 0;
    int fails = 0;
    int n;

    note_sequencer dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .buttons(buttons), .note_active(note_active), .note_y(note_y),
        .score(score), .combo(combo), .misses(misses), .state(state),
        .hit_pulse(hit_pulse)
    );

    // same stimulus, huge base points so the second hit overflows the display limit
    note_sequencer #(.POINTS(600000)) dut_b (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .buttons(buttons), .note_active(note_active_b), .note_y(note_y_b),
        .score(score_b), .combo(combo_b), .misses(misses_b), .state(state_b),
        .hit_pulse(hit_pulse_b)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(negedge clock); frame_tick = 1'b1;
            @(negedge clock); frame_tick = 1'b0;
        end
    endtask

    task automatic press(input int lane);
        @(negedge clock); buttons[lane] = 1'b1;
        @(negedge clock); buttons = 4'b0;
    endtask

    task automatic do_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_state", state, 0);
        check("rst_score", score, 0);
        check("rst_combo", combo, 0);
        check("rst_misses", misses, 0);
        check("rst_active", note_active, 0);
        check("rst_y", note_y, 0);
        check("rst_hit", hit_pulse, 0);
        @(negedge clock); reset = 1'b1;

        do_start();
        check("start_play", state, 1);

        tick(29);
        check("no_spawn_29", note_active, 4'b0000);
        tick(1);
        check("spawn_lane1", note_active, 4'b0010);
        check("spawn_y1", note_y[19:10], 0);

        tick(100);                     // t=130: lane1 y=400, lane2 (t60) y=280
        check("y1_at_130", note_y[19:10], 400);
        check("y2_at_130", note_y[29:20], 280);
        check("active_130", note_active, 4'b0110);

        press(1);
        check("hit_pulse1", hit_pulse, 4'b0010);
        check("hit_score", score, 10);
        check("hit_combo", combo, 1);
        check("hit_clear", note_active, 4'b0100);
        check("b_score_1", score_b, 600000);
        @(negedge clock);
        check("hit_pulse_gone", hit_pulse, 4'b0000);

        press(3);                      // lane 3 empty
        check("empty_combo", combo, 0);
        check("empty_score", score, 10);

        tick(20);                      // t=150: lane0 spawns
        check("active_150", note_active, 4'b0101);
        tick(29);                      // t=179
        check("y2_at_179", note_y[29:20], 476);
        check("no_miss_179", misses, 0);
        tick(1);                       // t=180: lane2 misses, lane1 spawns
        check("miss_y2", note_y[29:20], 480);
        check("miss_count", misses, 1);
        check("miss_combo", combo, 0);
        check("active_180", note_active, 4'b0011);

        tick(72);                      // t=252: lane3 spawned t210, lane0 y=408
        check("active_252", note_active, 4'b1011);
        check("y0_at_252", note_y[9:0], 408);
        press(0);
        check("hit0_pulse", hit_pulse, 4'b0001);
        check("hit0_score", score, 20);
        check("hit0_combo", combo, 1);
        check("b_score_sat", score_b, 999999);

        n = 0;
        while (state != 2'b10 && n < 3000) begin
            tick(1);
            n++;
        end
        check("over_state", state, 2);
        check("over_misses", misses, 8);
        check("over_score", score, 20);
        tick(10);
        press(1);
        check("frozen_state", state, 2);
        check("frozen_misses", misses, 8);
        check("frozen_score", score, 20);
        check("frozen_hit", hit_pulse, 0);

        do_start();
        check("restart_state", state, 1);
        check("restart_score", score, 0);
        check("restart_misses", misses, 0);
        check("restart_active", note_active, 0);
        check("restart_b_score", score_b, 0);

        tick(30);
        check("restart_spawn", $countones(note_active), 1);
        #3 reset = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_active", note_active, 0);
        check("arst_y", note_y, 0);
        check("arst_score", score, 0);
        check("arst_misses", misses, 0);
        check("arst_hit", hit_pulse, 0);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        check("post_rst_idle", state, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
